// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
`default_nettype none

interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the fetch PC, fetches over req/ack, feeds IF/ID
// through an output register plus a one-entry skid, and handles stall and redirect.
`default_nettype none

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    if_fetch_unit_if.master   imem,
    input  wire logic         stall_in,
    input  wire logic         redirect_in,
    input  wire logic [31:0]  redirect_pc,
    output logic [31:0]       instr_out,
    output logic [31:0]       pc_4_out,
    output logic              valid_out,
    output logic              flush_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] target_q;
    logic        req_q;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc_4;

    logic [31:0] target;
    logic [31:0] addr_plus_4;
    logic        xfer;
    logic        consume;
    logic        skid_fill;

    assign imem.req    = req_q;
    assign imem.addr   = addr_q;
    assign target      = {redirect_pc[31:2], 2'b00};
    assign addr_plus_4 = addr_q + 32'd4;
    assign xfer        = req_q & imem.ack;
    assign consume     = valid_out & ~stall_in;
    // The request is gated off while the skid is full, so a fill only happens into an empty skid.
    assign skid_fill   = xfer & valid_out & ~consume;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= RESET_PC;
            target_q   <= 32'h0;
            req_q      <= 1'b0;
            skid_valid <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_pc_4  <= 32'h0;
            valid_out  <= 1'b0;
            instr_out  <= NOP_INSTR;
            pc_4_out   <= 32'h0;
            flush_out  <= 1'b0;
        end else begin
            flush_out <= 1'b0;
            if (redirect_in) begin
                valid_out  <= 1'b0;
                instr_out  <= NOP_INSTR;
                skid_valid <= 1'b0;
                flush_out  <= 1'b1;
                req_q      <= 1'b1;
                // An outstanding request must still see its ack before the new address is issued.
                if (!req_q || imem.ack) begin
                    addr_q <= target;
                    state  <= FETCH;
                end else begin
                    target_q <= target;
                    state    <= DRAIN;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state <= FETCH;
                        req_q <= 1'b1;
                    end
                    DRAIN: begin
                        if (imem.ack) begin
                            addr_q <= target_q;
                            state  <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (xfer) begin
                            addr_q <= addr_plus_4;
                        end
                        if (consume) begin
                            if (skid_valid) begin
                                instr_out  <= skid_instr;
                                pc_4_out   <= skid_pc_4;
                                skid_valid <= 1'b0;
                            end else if (xfer) begin
                                instr_out <= imem.rdata;
                                pc_4_out  <= addr_plus_4;
                            end else begin
                                valid_out <= 1'b0;
                                instr_out <= NOP_INSTR;
                            end
                        end else if (xfer) begin
                            if (valid_out) begin
                                skid_instr <= imem.rdata;
                                skid_pc_4  <= addr_plus_4;
                                skid_valid <= 1'b1;
                            end else begin
                                instr_out <= imem.rdata;
                                pc_4_out  <= addr_plus_4;
                                valid_out <= 1'b1;
                            end
                        end
                        req_q <= ~(skid_fill | (skid_valid & ~consume));
                    end
                    default: begin
                        state <= IDLE;
                        req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit; one task per scenario.
`default_nettype none

module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n0;
    logic        rst_n1;
    logic        stall0;
    logic        stall1;
    logic        redir0;
    logic        redir1;
    logic [31:0] redir_pc0;
    logic [31:0] redir_pc1;
    logic [31:0] instr0;
    logic [31:0] instr1;
    logic [31:0] pc4_0;
    logic [31:0] pc4_1;
    logic        valid0;
    logic        valid1;
    logic        flush0;
    logic        flush1;

    int checks;
    int errors;

    if_fetch_unit_if bus0 ();
    if_fetch_unit_if bus1 ();

    if_fetch_unit #(.RESET_PC(32'h0000_0400), .NOP_INSTR(32'h0000_0000)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n0),
        .imem        (bus0.master),
        .stall_in    (stall0),
        .redirect_in (redir0),
        .redirect_pc (redir_pc0),
        .instr_out   (instr0),
        .pc_4_out    (pc4_0),
        .valid_out   (valid0),
        .flush_out   (flush0)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n1),
        .imem        (bus1.master),
        .stall_in    (stall1),
        .redirect_in (redir1),
        .redirect_pc (redir_pc1),
        .instr_out   (instr1),
        .pc_4_out    (pc4_1),
        .valid_out   (valid1),
        .flush_out   (flush1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset0();
        rst_n0        = 1'b0;
        stall0        = 1'b0;
        redir0        = 1'b0;
        redir_pc0     = 32'h0;
        bus0.ack      = 1'b0;
        bus0.rdata    = 32'h0;
        tick();
        rst_n0 = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n0     = 1'b0;
        stall0     = 1'b0;
        redir0     = 1'b0;
        redir_pc0  = 32'h0;
        bus0.ack   = 1'b0;
        bus0.rdata = 32'h0;
        tick();
        checks++;
        if ({bus0.req, valid0, instr0, pc4_0, flush0} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got req=%b valid=%b instr=%h pc4=%h flush=%b required 0/0/0/0/0",
                     bus0.req, valid0, instr0, pc4_0, flush0);
        end
        rst_n0 = 1'b1;
        tick();
        checks++;
        if ({bus0.req, bus0.addr, valid0, instr0} !== {1'b1, 32'h400, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL first_req got req=%b addr=%h valid=%b instr=%h required 1/00000400/0/0",
                     bus0.req, bus0.addr, valid0, instr0);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] words [3];
        words[0] = 32'hAAAA_0001;
        words[1] = 32'hBBBB_0002;
        words[2] = 32'hCCCC_0003;
        reset0();
        bus0.ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus0.rdata = words[i];
            tick();
            checks++;
            if ({valid0, instr0, pc4_0, bus0.addr} !==
                {1'b1, words[i], 32'h404 + 32'(4 * i), 32'h404 + 32'(4 * i)}) begin
                errors++;
                $display("FAIL zero_wait_%0d got valid=%b instr=%h pc4=%h addr=%h required 1/%h/%h/%h",
                         i, valid0, instr0, pc4_0, bus0.addr, words[i],
                         32'h404 + 32'(4 * i), 32'h404 + 32'(4 * i));
            end
        end
        bus0.ack = 1'b0;
        tick();
        checks++;
        if ({valid0, instr0} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL zero_wait_bubble got valid=%b instr=%h required 0/00000000", valid0, instr0);
        end
    endtask

    task automatic test_stall();
        reset0();
        stall0     = 1'b1;
        bus0.ack   = 1'b1;
        bus0.rdata = 32'hA0A0_0001;
        tick();
        bus0.rdata = 32'hB0B0_0002;
        tick();
        checks++;
        if ({valid0, instr0, pc4_0, bus0.req} !== {1'b1, 32'hA0A0_0001, 32'h404, 1'b0}) begin
            errors++;
            $display("FAIL stall_skid_full got valid=%b instr=%h pc4=%h req=%b required 1/a0a00001/00000404/0",
                     valid0, instr0, pc4_0, bus0.req);
        end
        bus0.rdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if ({instr0, bus0.req, bus0.addr} !== {32'hA0A0_0001, 1'b0, 32'h408}) begin
            errors++;
            $display("FAIL stall_hold got instr=%h req=%b addr=%h required a0a00001/0/00000408",
                     instr0, bus0.req, bus0.addr);
        end
        stall0 = 1'b0;
        tick();
        checks++;
        if ({valid0, instr0, pc4_0, bus0.req} !== {1'b1, 32'hB0B0_0002, 32'h408, 1'b1}) begin
            errors++;
            $display("FAIL stall_release_b got valid=%b instr=%h pc4=%h req=%b required 1/b0b00002/00000408/1",
                     valid0, instr0, pc4_0, bus0.req);
        end
        bus0.rdata = 32'hC0C0_0003;
        tick();
        checks++;
        if ({valid0, instr0, pc4_0, bus0.addr} !== {1'b1, 32'hC0C0_0003, 32'h40C, 32'h40C}) begin
            errors++;
            $display("FAIL stall_release_c got valid=%b instr=%h pc4=%h addr=%h required 1/c0c00003/0000040c/0000040c",
                     valid0, instr0, pc4_0, bus0.addr);
        end
        bus0.ack = 1'b0;
        tick();
        checks++;
        if (valid0 !== 1'b0) begin
            errors++;
            $display("FAIL stall_no_dup got valid=%b required 0", valid0);
        end
    endtask

    task automatic test_redirect_drain();
        reset0();
        redir0    = 1'b1;
        redir_pc0 = 32'h0000_0803;
        tick();
        checks++;
        if ({flush0, valid0, bus0.req, bus0.addr} !== {1'b1, 1'b0, 1'b1, 32'h400}) begin
            errors++;
            $display("FAIL drain_enter got flush=%b valid=%b req=%b addr=%h required 1/0/1/00000400",
                     flush0, valid0, bus0.req, bus0.addr);
        end
        redir0 = 1'b0;
        tick();
        checks++;
        if ({flush0, valid0, bus0.req, bus0.addr} !== {1'b0, 1'b0, 1'b1, 32'h400}) begin
            errors++;
            $display("FAIL drain_wait got flush=%b valid=%b req=%b addr=%h required 0/0/1/00000400",
                     flush0, valid0, bus0.req, bus0.addr);
        end
        bus0.ack   = 1'b1;
        bus0.rdata = 32'hBAD0_0000;
        tick();
        checks++;
        if ({valid0, instr0, bus0.req, bus0.addr} !== {1'b0, 32'h0, 1'b1, 32'h800}) begin
            errors++;
            $display("FAIL drain_ack got valid=%b instr=%h req=%b addr=%h required 0/00000000/1/00000800",
                     valid0, instr0, bus0.req, bus0.addr);
        end
        bus0.ack = 1'b0;
        tick();
        checks++;
        if ({valid0, bus0.addr, flush0} !== {1'b0, 32'h800, 1'b0}) begin
            errors++;
            $display("FAIL drain_after got valid=%b addr=%h flush=%b required 0/00000800/0",
                     valid0, bus0.addr, flush0);
        end
    endtask

    task automatic test_redirect_collision();
        reset0();
        stall0     = 1'b1;
        bus0.ack   = 1'b1;
        bus0.rdata = 32'h1111_0001;
        tick();
        bus0.rdata = 32'h2222_0002;
        tick();
        redir0     = 1'b1;
        redir_pc0  = 32'h0000_0A00;
        bus0.rdata = 32'h3333_0003;
        tick();
        checks++;
        if ({valid0, instr0, flush0, bus0.req, bus0.addr} !== {1'b0, 32'h0, 1'b1, 1'b1, 32'hA00}) begin
            errors++;
            $display("FAIL collide got valid=%b instr=%h flush=%b req=%b addr=%h required 0/00000000/1/1/00000a00",
                     valid0, instr0, flush0, bus0.req, bus0.addr);
        end
        redir0   = 1'b0;
        stall0   = 1'b0;
        bus0.ack = 1'b0;
        tick();
        checks++;
        if ({valid0, flush0} !== {1'b0, 1'b0}) begin
            errors++;
            $display("FAIL collide_skid_empty got valid=%b flush=%b required 0/0", valid0, flush0);
        end
        bus0.ack   = 1'b1;
        bus0.rdata = 32'h4444_0004;
        tick();
        checks++;
        if ({valid0, instr0, pc4_0} !== {1'b1, 32'h4444_0004, 32'hA04}) begin
            errors++;
            $display("FAIL collide_refetch got valid=%b instr=%h pc4=%h required 1/44440004/00000a04",
                     valid0, instr0, pc4_0);
        end
        bus0.ack = 1'b0;
    endtask

    task automatic test_wrap_async();
        rst_n1     = 1'b0;
        stall1     = 1'b0;
        redir1     = 1'b0;
        redir_pc1  = 32'h0;
        bus1.ack   = 1'b0;
        bus1.rdata = 32'h0;
        tick();
        rst_n1 = 1'b1;
        tick();
        checks++;
        if ({bus1.req, bus1.addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_first got req=%b addr=%h required 1/fffffffc", bus1.req, bus1.addr);
        end
        bus1.ack   = 1'b1;
        bus1.rdata = 32'h5555_0005;
        tick();
        checks++;
        if ({valid1, instr1, pc4_1, bus1.addr} !== {1'b1, 32'h5555_0005, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL wrap got valid=%b instr=%h pc4=%h addr=%h required 1/55550005/00000000/00000000",
                     valid1, instr1, pc4_1, bus1.addr);
        end
        bus1.ack = 1'b0;
        stall1   = 1'b1;
        tick();
        #2;
        rst_n1 = 1'b0;
        #1;
        checks++;
        if ({bus1.req, valid1} !== {1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got req=%b valid=%b required 0/0", bus1.req, valid1);
        end
        tick();
        rst_n1 = 1'b1;
        stall1 = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n1     = 1'b0;
        stall1     = 1'b0;
        redir1     = 1'b0;
        redir_pc1  = 32'h0;
        bus1.ack   = 1'b0;
        bus1.rdata = 32'h0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_drain();
        test_redirect_collision();
        test_wrap_async();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
